// File: rtl/dmem_responder.sv
// Single-port data memory responder: accepts one request, waits a programmable delay, then reads or strobe-writes.
// Optional macro DMEM_RESP_RANDLAT_EN adds an LFSR-driven random extra delay of 0..7 cycles.
module dmem_responder #(
    parameter int DEPTH   = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        mem_instr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o
);

    localparam int WORDS = 1 << DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [4:0]         load_cnt;
    logic [DEPTH-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic               accept;
    logic               access;
    logic               wr;

    // Instruction flag and non-index address bits have no effect on behaviour.
    logic unused_w;
    assign unused_w = ^{mem_instr_i, mem_addr_i[31:DEPTH+2], mem_addr_i[1:0]};

`ifdef DMEM_RESP_RANDLAT_EN
    logic [15:0] lfsr_q;

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign load_cnt = 5'(LATENCY) + {2'b00, lfsr_q[2:0]};
`else
    assign load_cnt = 5'(LATENCY);
`endif

    assign wr          = |wstrb_q;
    assign mem_ready_o = (state_q == ST_RESP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid_i) begin
                    accept  = 1'b1;
                    cnt_d   = load_cnt;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 5'd0) begin
                    access  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= mem_addr_i[DEPTH+1:2];
                wdata_q <= mem_wdata_i;
                wstrb_q <= mem_wstrb_i;
            end
        end
    end

    // One byte-wide RAM per lane so each lane's strobe maps to its own write enable.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_q [0:WORDS-1];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (access && !rst && wstrb_q[gi]) begin
                lane_q[idx_q] <= wdata_q[gi*8 +: 8];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= 8'h00;
            end else if (access) begin
                rd_q <= wr ? 8'h00 : lane_q[idx_q];
            end
        end

        assign mem_rdata_o[gi*8 +: 8] = rd_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_dmem_responder;

    localparam int DEPTH = 10;
    localparam int L     = 2;

    logic        clk;
    logic        rst;
    logic        mem_valid_i;
    logic        mem_instr_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_wstrb_i;
    logic        mem_ready_o;
    logic [31:0] mem_rdata_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model_mem [int];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_valid_i (mem_valid_i),
        .mem_instr_i (mem_instr_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wstrb_i (mem_wstrb_i),
        .mem_ready_o (mem_ready_o),
        .mem_rdata_o (mem_rdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Acceptable acceptance-to-ready distance in cycles.
    function automatic bit lat_ok(input int lat);
`ifdef DMEM_RESP_RANDLAT_EN
        return (lat >= 2 + L) && (lat <= 9 + L);
`else
        return lat == 2 + L;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % (1 << DEPTH));
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] wstrb);
        logic [31:0] w;
        int k;
        k = word_of(addr);
        w = model_mem.exists(k) ? model_mem[k] : 32'd0;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
        end
        model_mem[k] = w;
    endfunction

    // Drive one request from an IDLE cycle; returns in the following IDLE cycle.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rdata, output int lat, output bit ok);
        mem_valid_i = 1'b1;
        mem_instr_i = $urandom_range(0, 1) == 1;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        mem_wstrb_i = wstrb;
        lat   = 0;
        ok    = 1'b0;
        rdata = 32'd0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (mem_ready_o) begin
                lat   = c;
                rdata = mem_rdata_o;
                ok    = 1'b1;
                break;
            end
        end
        mem_valid_i = 1'b0;
        mem_wstrb_i = 4'd0;
        @(posedge clk);
        #1;
        $display("txn addr=%08h wstrb=%h wdata=%08h rdata=%08h lat=%0d", addr, wstrb, wdata, rdata, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (mem_ready_o !== 1'b0 || mem_rdata_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b rdata=%08h, required ready=0 rdata=0", mem_ready_o, mem_rdata_o);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (mem_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: ready=%b, required 0", mem_ready_o);
        end
    endtask

    task automatic test_full_word();
        logic [31:0] rd;
        int lat;
        bit ok;
        do_req(32'h10, 32'hDEADBEEF, 4'hF, rd, lat, ok);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        n_cmp++;
        if (!ok || rd !== 32'd0) begin
            n_err++;
            $display("FAIL write_rdata: got %08h ok=%0d, required 00000000", rd, ok);
        end
        do_req(32'h10, 32'h0, 4'h0, rd, lat, ok);
        n_cmp++;
        if (!ok || rd !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL read_full: got %08h, required deadbeef", rd);
        end
        n_cmp++;
        if (!ok || !lat_ok(lat)) begin
            n_err++;
            $display("FAIL read_latency: got %0d cycles, required %0d", lat, 2 + L);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        int lat;
        bit ok;
        do_req(32'h20, 32'h11223344, 4'hF, rd, lat, ok);
        do_req(32'h20, 32'hAABBCCDD, 4'b0101, rd, lat, ok);
        model_write(32'h20, 32'h11223344, 4'hF);
        model_write(32'h20, 32'hAABBCCDD, 4'b0101);
        do_req(32'h20, 32'h0, 4'h0, rd, lat, ok);
        n_cmp++;
        if (!ok || rd !== 32'h11BB33DD) begin
            n_err++;
            $display("FAIL strobe_merge: got %08h, required 11bb33dd", rd);
        end
    endtask

    task automatic test_alias();
        logic [31:0] rd;
        int lat;
        bit ok;
        do_req(32'h1004, 32'h5A5A5A5A, 4'hF, rd, lat, ok);
        model_write(32'h1004, 32'h5A5A5A5A, 4'hF);
        do_req(32'h0004, 32'h0, 4'h0, rd, lat, ok);
        n_cmp++;
        if (!ok || rd !== 32'h5A5A5A5A) begin
            n_err++;
            $display("FAIL alias_high: got %08h, required 5a5a5a5a", rd);
        end
        do_req(32'hFFFF_F007, 32'h0, 4'h0, rd, lat, ok);
        n_cmp++;
        if (!ok || rd !== 32'h5A5A5A5A) begin
            n_err++;
            $display("FAIL alias_lowbits: got %08h, required 5a5a5a5a", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        bit ok;
        int pulses;
        int last_c;
        bit space_bad;
        bit data_bad;
        do_req(32'h30, 32'hCAFEF00D, 4'hF, rd, lat, ok);
        model_write(32'h30, 32'hCAFEF00D, 4'hF);
        pulses = 0;
        last_c = 0;
        space_bad = 1'b0;
        data_bad = 1'b0;
        mem_valid_i = 1'b1;
        mem_addr_i  = 32'h30;
        mem_wstrb_i = 4'h0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1;
            if (mem_ready_o) begin
                pulses++;
                if (mem_rdata_o !== 32'hCAFEF00D) data_bad = 1'b1;
`ifndef DMEM_RESP_RANDLAT_EN
                if (pulses > 1 && c - last_c != L + 3) space_bad = 1'b1;
`endif
                $display("txn b2b pulse=%0d cycle=%0d rdata=%08h", pulses, c, mem_rdata_o);
                last_c = c;
                if (pulses == 3) mem_valid_i = 1'b0;
            end
        end
        mem_valid_i = 1'b0;
        n_cmp++;
        if (pulses != 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d pulses, required 3", pulses);
        end
        n_cmp++;
        if (space_bad) begin
            n_err++;
            $display("FAIL b2b_spacing: pulse spacing not %0d cycles", L + 3);
        end
        n_cmp++;
        if (data_bad) begin
            n_err++;
            $display("FAIL b2b_data: rdata differed from cafef00d on a pulse");
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        int lat;
        bit ok;
        bit out_bad;
        do_req(32'h40, 32'h0, 4'hF, rd, lat, ok);
        model_write(32'h40, 32'h0, 4'hF);
        do_req(32'h10, 32'h0, 4'h0, rd, lat, ok);
        // Start a write, then reset while it is waiting.
        mem_valid_i = 1'b1;
        mem_addr_i  = 32'h40;
        mem_wdata_i = 32'hFFFFFFFF;
        mem_wstrb_i = 4'hF;
        @(posedge clk);
        #1;
        mem_valid_i = 1'b0;
        mem_wstrb_i = 4'h0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_bad = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (mem_ready_o !== 1'b0 || mem_rdata_o !== 32'd0) out_bad = 1'b1;
            @(posedge clk);
            #1;
        end
        $display("txn abort addr=00000040 outputs_nonzero=%0d", out_bad);
        n_cmp++;
        if (out_bad) begin
            n_err++;
            $display("FAIL abort_outputs: ready/rdata nonzero after reset, required 0");
        end
        do_req(32'h40, 32'h0, 4'h0, rd, lat, ok);
        n_cmp++;
        if (!ok || rd !== 32'h0) begin
            n_err++;
            $display("FAIL abort_nowrite: got %08h, required 00000000", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
        int lat;
        bit ok;
        int idx;
        for (int i = 64; i < 96; i++) begin
            wdata = $urandom;
            do_req(32'(i) << 2, wdata, 4'hF, rd, lat, ok);
            model_write(32'(i) << 2, wdata, 4'hF);
        end
        for (int t = 0; t < 300; t++) begin
            idx   = $urandom_range(64, 95);
            addr  = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
            wdata = $urandom;
            wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            exp   = (wstrb != 4'h0) ? 32'd0 : model_mem[word_of(addr)];
            do_req(addr, wdata, wstrb, rd, lat, ok);
            if (wstrb != 4'h0) model_write(addr, wdata, wstrb);
            n_cmp++;
            if (!ok || rd !== exp) begin
                n_err++;
                $display("FAIL rand_data[%0d]: addr=%08h got %08h, required %08h", t, addr, rd, exp);
            end
            n_cmp++;
            if (!ok || !lat_ok(lat)) begin
                n_err++;
                $display("FAIL rand_latency[%0d]: got %0d cycles, required %0d", t, lat, 2 + L);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        mem_valid_i = 1'b0;
        mem_instr_i = 1'b0;
        mem_addr_i  = 32'd0;
        mem_wdata_i = 32'd0;
        mem_wstrb_i = 4'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_full_word();
        test_strobe();
        test_alias();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
